// File: rtl/deinterleaver.sv
// QPSK block deinterleaver: ping-pong bit banks, serial in/out with
// ready/valid, reads in row/column order to undo the interleave.
module deinterleaver #(
  parameter int N_CBPS = 192,
  parameter int D      = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic valid_in,
  input  logic data_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out,
  input  logic ready_in
);

  localparam int ROWS = N_CBPS / D;
  localparam int AW   = $clog2(N_CBPS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (D > 1) ? $clog2(D) : 1;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_CBPS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(D - 1);
  localparam logic [AW-1:0] ROWS_A   = AW'(ROWS);

  logic [N_CBPS-1:0] mem [2];

  logic [1:0]    bank_full;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_idx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] rd_addr;

  logic wr_fire;
  logic rd_fire;
  logic wr_last;
  logic rd_last;

  assign ready_out = ~bank_full[wr_bank];
  assign valid_out = bank_full[rd_bank];

  assign wr_fire = valid_in & ready_out;
  assign rd_fire = valid_out & ready_in;
  assign wr_last = wr_fire & (wr_idx == LAST_IDX);
  assign rd_last = rd_fire & (row == LAST_ROW)
                 & (col == LAST_COL);

  // Constant multiply only; no divider needed.
  assign rd_addr = ROWS_A * AW'(col) + AW'(row);

  assign data_out = valid_out ? mem[rd_bank][rd_addr]
                              : 1'b0;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      row     <= '0;
      col     <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (row == LAST_ROW) begin
          row     <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Set and clear always target different banks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bank_full <= '0;
    end else begin
      if (wr_last) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (rd_last) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

endmodule
